// File: rtl/gate_seq_ctrl.sv
// gate_seq_ctrl: measurement sequencer; clears the BCD counter, opens an exact gate, settles, then
// issues the display latch strobe aligned to a fresh vblank rising edge (or after a timeout).
module gate_seq_ctrl #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SETTLE_CYCLES = 8,
  parameter int STROBE_CYCLES = 4,
  parameter int VB_TIMEOUT    = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [1:0] gate_sel,
  input  logic       vblank_async,
  input  logic       cnt_ovf,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       strobe,
  output logic       range_ovf,
  output logic [1:0] gate_sel_q,
  output logic       vb_miss,
  output logic       busy
);
  localparam logic [31:0] G0 = 32'(CLK_HZ);
  localparam logic [31:0] G1 = 32'(CLK_HZ / 10);
  localparam logic [31:0] G2 = 32'(CLK_HZ / 100);
  localparam logic [31:0] G3 = 32'(CLK_HZ / 1000);
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, WAIT_VB, LATCH} state_t;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, tmo_q, tmo_d, glen;
  logic [2:0]  vb_q, vb_d;
  logic [1:0]  sel_q, sel_d, lsel_q, lsel_d;
  logic        ovf_acc_q, ovf_acc_d, lovf_q, lovf_d, lmiss_q, lmiss_d, vb_rise;
  assign glen = gate_sel == 2'd0 ? G0 : gate_sel == 2'd1 ? G1 : gate_sel == 2'd2 ? G2 : G3;
  // vb_q[1:0] is the two-flop synchronizer, vb_q[2] the previous synchronized level
  assign vb_rise = vb_q[1] & ~vb_q[2];
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    sel_d     = sel_q;
    ovf_acc_d = ovf_acc_q;
    lsel_d    = lsel_q;
    lovf_d    = lovf_q;
    lmiss_d   = lmiss_q;
    vb_d      = {vb_q[1:0], vblank_async};
    case (state_q)
      IDLE: state_d = run ? CLEAR : IDLE;
      CLEAR: begin
        state_d   = GATE;
        sel_d     = gate_sel;
        ovf_acc_d = 1'b0;
        cnt_d     = glen - 32'd1;
      end
      GATE: begin
        ovf_acc_d = ovf_acc_q | cnt_ovf;
        cnt_d     = cnt_q == '0 ? 32'(SETTLE_CYCLES - 1) : cnt_q - 32'd1;
        state_d   = cnt_q == '0 ? SETTLE : GATE;
      end
      SETTLE: begin
        ovf_acc_d = ovf_acc_q | cnt_ovf;
        cnt_d     = cnt_q - 32'd1;
        tmo_d     = '0;
        state_d   = cnt_q == '0 ? WAIT_VB : SETTLE;
      end
      WAIT_VB: begin
        tmo_d = tmo_q + 32'd1;
        if (vb_rise || tmo_q == 32'(VB_TIMEOUT - 1)) begin
          state_d = LATCH;
          cnt_d   = 32'(STROBE_CYCLES - 1);
          lovf_d  = ovf_acc_q;
          lsel_d  = sel_q;
          lmiss_d = ~vb_rise;
        end
      end
      LATCH: begin
        cnt_d   = cnt_q - 32'd1;
        state_d = cnt_q != '0 ? LATCH : run ? CLEAR : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      sel_q     <= '0;
      ovf_acc_q <= 1'b0;
      lsel_q    <= '0;
      lovf_q    <= 1'b0;
      lmiss_q   <= 1'b0;
      vb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      sel_q     <= sel_d;
      ovf_acc_q <= ovf_acc_d;
      lsel_q    <= lsel_d;
      lovf_q    <= lovf_d;
      lmiss_q   <= lmiss_d;
      vb_q      <= vb_d;
    end
  assign cnt_clr    = state_q == CLEAR;
  assign cnt_en     = state_q == GATE;
  assign strobe     = state_q == LATCH;
  assign busy       = state_q != IDLE;
  assign range_ovf  = lovf_q;
  assign gate_sel_q = lsel_q;
  assign vb_miss    = lmiss_q;
endmodule
